// File: rtl/bus_demux.sv
// Single-initiator data-memory demux: decodes addr[SEL_LSB+3:SEL_LSB] to one of four
// targets, one outstanding transaction, timeout/decode errors. Optional err_cnt via BUS_DEMUX_ERR_COUNT_EN.
module bus_demux #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 32,
    parameter int SEL_LSB = 28,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [WIDTH-1:0]  m_wdata,
    output logic              m_ready,
    output logic              m_rvalid,
    output logic [WIDTH-1:0]  m_rdata,
    output logic              m_err,
    output logic [3:0]        t_req,
    output logic              t_we,
    output logic [ADDR_W-1:0] t_addr,
    output logic [WIDTH-1:0]  t_wdata,
    input  logic [3:0]        t_ack,
    input  logic [WIDTH-1:0]  t_rdata0,
    input  logic [WIDTH-1:0]  t_rdata1,
    input  logic [WIDTH-1:0]  t_rdata2,
    input  logic [WIDTH-1:0]  t_rdata3
`ifdef BUS_DEMUX_ERR_COUNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // The busy counter starts at 0 on entry, so expiry is one short of TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic [3:0]         r_t_req;
    logic               r_t_we;
    logic [ADDR_W-1:0]  r_t_addr;
    logic [WIDTH-1:0]   r_t_wdata;
    logic               r_m_rvalid;
    logic [WIDTH-1:0]   r_m_rdata;
    logic               r_m_err;

    logic [3:0]         w_region;
    logic               w_hit;
    logic [WIDTH-1:0]   w_rdata_in    [4];
    logic [WIDTH-1:0]   w_rdata_gated [4];
    logic [WIDTH-1:0]   w_rdata_sel;

    assign w_region = m_addr[SEL_LSB +: 4];
    assign w_hit    = |(t_ack & r_t_req);

    assign w_rdata_in[0] = t_rdata0;
    assign w_rdata_in[1] = t_rdata1;
    assign w_rdata_in[2] = t_rdata2;
    assign w_rdata_in[3] = t_rdata3;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gate
            assign w_rdata_gated[gi] = r_t_req[gi] ? w_rdata_in[gi] : '0;
        end
    endgenerate

    always_comb begin
        w_rdata_sel = '0;
        for (int i = 0; i < 4; i++) begin
            w_rdata_sel = w_rdata_sel | w_rdata_gated[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_t_req    <= '0;
            r_t_we     <= 1'b0;
            r_t_addr   <= '0;
            r_t_wdata  <= '0;
            r_m_rvalid <= 1'b0;
            r_m_rdata  <= '0;
            r_m_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m_req) begin
                        r_t_we    <= m_we;
                        r_t_addr  <= m_addr;
                        r_t_wdata <= m_wdata;
                        if (w_region[3:2] == 2'b00) begin
                            r_t_req <= 4'b0001 << w_region[1:0];
                            r_cnt   <= '0;
                            r_state <= S_BUSY;
                        end else begin
                            r_m_rvalid <= 1'b1;
                            r_m_err    <= 1'b1;
                            r_m_rdata  <= '0;
                            r_state    <= S_RESP;
                        end
                    end
                end
                S_BUSY: begin
                    // Ack is checked before expiry so a same-cycle ack still succeeds.
                    if (w_hit) begin
                        r_m_rdata  <= r_t_we ? '0 : w_rdata_sel;
                        r_m_err    <= 1'b0;
                        r_m_rvalid <= 1'b1;
                        r_t_req    <= '0;
                        r_state    <= S_RESP;
                    end else if (r_cnt == TO_LAST) begin
                        r_m_rdata  <= '0;
                        r_m_err    <= 1'b1;
                        r_m_rvalid <= 1'b1;
                        r_t_req    <= '0;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_m_rvalid <= 1'b0;
                    r_m_err    <= 1'b0;
                    r_m_rdata  <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BUS_DEMUX_ERR_COUNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (r_state == S_RESP && r_m_err && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign m_ready  = (r_state == S_IDLE) & rst_n;
    assign m_rvalid = r_m_rvalid;
    assign m_rdata  = r_m_rdata;
    assign m_err    = r_m_err;
    assign t_req    = r_t_req;
    assign t_we     = r_t_we;
    assign t_addr   = r_t_addr;
    assign t_wdata  = r_t_wdata;

endmodule
